// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM encoding, drain
// length helper and the lane-slice macro for DIM*DATA_WIDTH packed vectors.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // Cycles needed after the last slice until the far-corner PE has consumed
  // its final operand pair.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// Lane idx of a packed vector whose lanes are w bits wide.
`ifndef FEEDER_LANE
`define FEEDER_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/systolic_feeder_skew.sv
// skew_line: DEPTH-stage shift register with advance enable and synchronous
// clear. Lane i of the feeder uses DEPTH = i+1 to build the diagonal wavefront.
module skew_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];

  // Next-stage values: clear wins over advance, otherwise hold.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) stage_d[s] = stage_q[s];
    if (clr_i) begin
      for (int s = 0; s < DEPTH; s++) stage_d[s] = '0;
    end else if (adv_i) begin
      stage_d[0] = d_i;
      for (int s = 1; s < DEPTH; s++) stage_d[s] = stage_q[s-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A columns / B rows into the west and north edges of
// a DIM x DIM systolic array and sequences the array enable.
// Optional macro FEEDER_STALL_CNT_EN adds stall_cnt_o, a saturating count of
// LOAD cycles without a valid slice.
//
// Handshake: a slice transfers on a rising edge where vec_valid_i and
// vec_ready_o are both high; vec_ready_o is high exactly in LOAD and does not
// depend on vec_valid_i.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [K_WIDTH-1:0]        k_len_i,
  input  logic                      vec_valid_i,
  output logic                      vec_ready_o,
  input  logic [DIM*DATA_WIDTH-1:0] vec_a_i,
  input  logic [DIM*DATA_WIDTH-1:0] vec_b_i,
  output logic [DIM*DATA_WIDTH-1:0] data_a_o,
  output logic [DIM*DATA_WIDTH-1:0] data_b_o,
  output logic                      start_operation_o,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      result_ack_i,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]               stall_cnt_o,
`endif
  output feeder_state_e             state_o
);

  localparam int DRAIN_CYCLES = drain_cycles(DIM);
  localparam int DC_W         = $clog2(DRAIN_CYCLES + 1);

  feeder_state_e      state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
  logic [DC_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic               start_op_q, start_op_d;
  logic               accept;

  assign accept = (state_q == ST_LOAD) && vec_valid_i;

  // Next state, slice/drain counters and the registered array enable.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    k_cnt_d     = k_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          k_len_d     = k_len_i;
          k_cnt_d     = '0;
          drain_cnt_d = '0;
          state_d     = (k_len_i != '0) ? ST_LOAD : ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (vec_valid_i) begin
          k_cnt_d = k_cnt_q + K_WIDTH'(1);
          if (k_cnt_q == k_len_q - K_WIDTH'(1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
        else drain_cnt_d = drain_cnt_q + DC_W'(1);
      end
      ST_DONE: begin
        // Ack wins over a concurrent start; that start is dropped.
        if (result_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    start_op_d = (state_d != ST_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
      start_op_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      start_op_q  <= start_op_d;
    end
  end

  assign vec_ready_o       = (state_q == ST_LOAD);
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = (state_q == ST_DONE);
  assign start_operation_o = start_op_q;
  assign state_o           = state_q;

  // Skew lines: zeros are shifted in on every non-accepting cycle so bubbles
  // and the drain tail contribute nothing to the PE accumulators.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_in, b_in;
    assign a_in = accept ? `FEEDER_LANE(vec_a_i, i, DATA_WIDTH) : '0;
    assign b_in = accept ? `FEEDER_LANE(vec_b_i, i, DATA_WIDTH) : '0;

    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_skew_a (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (state_q == ST_IDLE),
      .adv_i   (state_q != ST_IDLE),
      .d_i     (a_in),
      .q_o     (`FEEDER_LANE(data_a_o, i, DATA_WIDTH))
    );

    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_skew_b (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (state_q == ST_IDLE),
      .adv_i   (state_q != ST_IDLE),
      .d_i     (b_in),
      .q_o     (`FEEDER_LANE(data_b_o, i, DATA_WIDTH))
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of LOAD cycles without a slice; restarts with each job.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && start_i) stall_cnt_d = '0;
    else if (state_q == ST_LOAD && !vec_valid_i && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the processing-element data interface for a DIM x DIM systolic array.
- Accepts one column of A and one row of B per handshake: element k of every row, and element k of every column.
- Skews lane i by i cycles and drives the west-edge A inputs and north-edge B inputs of the array.
- Sequences the array's start_operation: asserts it for load and drain, holds results until acknowledged, then deasserts it to clear the accumulators.

Parameters:
- DATA_WIDTH, 8: width of one A/B element (signed two's complement).
- DIM, 4: array dimension, which is also the number of lanes.
- K_WIDTH, 8: width of the k_len_i length field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request to begin one matrix product.
- k_len_i  in  K_WIDTH  inner dimension K; sampled when start_i is accepted.
- vec_valid_i  in  1  vec_a_i and vec_b_i carry slice k.
- vec_ready_o  out  1  feeder accepts a slice this cycle.
- vec_a_i  in  DIM*DATA_WIDTH  lane i = A[i][k], at bits [i*DATA_WIDTH +: DATA_WIDTH].
- vec_b_i  in  DIM*DATA_WIDTH  lane j = B[k][j], same packing as vec_a_i.
- data_a_o  out  DIM*DATA_WIDTH  skewed A to the west-edge PE of row i.
- data_b_o  out  DIM*DATA_WIDTH  skewed B to the north-edge PE of column j.
- start_operation_o  out  1  array enable; low clears every PE.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  array results are final and stable.
- result_ack_i  in  1  consumer has read the array results.

Behaviour:
- Reset: all outputs 0, state IDLE, skew registers 0, counters 0. Reset mid-operation aborts immediately; the array clears because start_operation_o drops.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start_i=1 latches k_len_i.
  - If k_len_i != 0 the next state is LOAD; otherwise DRAIN.
- LOAD:
  - vec_ready_o=1.
  - Each cycle with vec_valid_i=1 accepts a slice and increments k_cnt.
  - When the K-th slice is accepted, the next state is DRAIN.
- DRAIN:
  - vec_ready_o=0.
  - Runs exactly DRAIN_CYCLES = 2*DIM-1 cycles, then goes to DONE.
- DONE:
  - done_o=1.
  - result_ack_i=1 returns to IDLE on the next edge.
- Output enables:
  - start_operation_o=1 in LOAD, DRAIN and DONE; 0 in IDLE. It is registered and asserts on the first LOAD/DRAIN cycle.
  - busy_o = (state != IDLE).
- Skew:
  - Every lane has a shift register that advances on every clock in LOAD and DRAIN.
  - The value shifted in is the lane of the accepted slice, or 0 on cycles with no acceptance: bubbles, DRAIN and DONE.
  - Lane i element accepted at edge t appears on data_a_o/data_b_o lane i after edge t+i+1. Latency is 1 for lane 0 and DIM for lane DIM-1.
  - Zero bubbles are mathematically neutral: the product term is 0.
- In IDLE the skew registers are cleared and the outputs are 0.
- Ignored inputs:
  - start_i while busy_o=1 is ignored.
  - result_ack_i outside DONE is ignored.
- Holding in DONE:
  - DONE is held indefinitely until result_ack_i.
  - data outputs stay 0, so the PE accumulators are stable.
- Simultaneous result_ack_i and start_i in DONE: the ack wins and the state goes to IDLE. start_i in that same cycle is dropped.
- No arithmetic is performed; elements pass through bit-exact, with signedness preserved.

Optional Feature:
- Macro FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [15:0].
  - Counts LOAD cycles with vec_valid_i=0 and saturates at 16'hFFFF.
  - Clears on reset and whenever a start_i is accepted.
  - Holds its value through DONE and IDLE.
- When undefined: the port and the counter are absent, with no other behavioural change.

Decomposition:
- Shared package/header holds:
  - the FSM state encoding (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DRAIN=2'd2, ST_DONE=2'd3);
  - the DRAIN_CYCLES expression;
  - the lane-slice macro for DIM*DATA_WIDTH packing.
- One natural sub-module: skew_line (parameters DATA_WIDTH, DEPTH).
  - A DEPTH-stage shift register with an advance enable and a synchronous clear.
  - Instantiated 2*DIM times with DEPTH = i+1.

Test Plan:
- Basic latency:
  - Stimulus: DIM=4, K=1, start_i; one slice with A lanes {1,2,3,4} and B lanes {5,6,7,8}.
  - Response: lane i nonzero exactly i+1 cycles after acceptance; DRAIN lasts 7 cycles; done_o rises; start_operation_o stays high until result_ack_i, then drops one cycle later.
- Full product:
  - Stimulus: K=4, array of 4x4 PEs attached, A = identity, B = values 1..16, slices streamed back-to-back.
  - Response: PE(i,j) accum_o equals B[i][j] when done_o=1; no overflow flags.
- Bubbles:
  - Stimulus: K=3 with vec_valid_i low for 2 cycles between slices, signed data A lanes = -128, B lanes = 127.
  - Response: accumulators equal 3*(-16256) = -48768, identical to the no-bubble run.
- K=0:
  - Response: IDLE to DRAIN directly; vec_ready_o never high; data outputs stay 0; done_o after 7 cycles.
- Reset mid-LOAD:
  - Stimulus: rst_n_i low during slice 2 of K=4.
  - Response: all outputs 0 asynchronously; state IDLE; a subsequent start_i behaves as from fresh reset.
- Ignored inputs, with FEEDER_STALL_CNT_EN defined:
  - start_i during DRAIN is ignored.
  - 5 idle LOAD cycles give stall_cnt_o=5.
